// File: rtl/multitap_text_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multitap_text_buffer_if : keypad-in / text-out bundle for the       |
// | multi-tap text buffer.                                              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface multitap_text_buffer_if #(
  parameter int DEPTH = 16
);
  logic                           key_valid;
  logic [7:0]                     key_code;
  logic                           mode;
  logic                           upper;
  logic [DEPTH*8-1:0]             buf_out;
  logic [7:0]                     pend_char;
  logic [$clog2(DEPTH+1)-1:0]     char_count;
  logic                           full;
  logic                           busy;
  logic [7:0]                     tx_data;
  logic                           tx_valid;
  logic                           tx_ready;

  modport master (
    output key_valid, key_code, mode, upper, tx_ready,
    input  buf_out, pend_char, char_count, full, busy, tx_data, tx_valid
  );

  modport slave (
    input  key_valid, key_code, mode, upper, tx_ready,
    output buf_out, pend_char, char_count, full, busy, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/multitap_text_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multitap_text_buffer : keypad multi-tap text entry with a shift     |
// | buffer and valid/ready serial drain. MULTITAP_TIMEOUT_EN adds an    |
// | idle auto-commit timer. Revision: 1.0                               |
// +--------------------------------------------------------------------+
module multitap_text_buffer #(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  multitap_text_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPOSE = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  localparam logic [3:0] K_STAR = 4'd10;
  localparam logic [3:0] K_HASH = 4'd11;
  localparam logic [3:0] K_A    = 4'd12;
  localparam logic [3:0] K_C    = 4'd13;
  localparam logic [3:0] K_D    = 4'd14;
  localparam logic [3:0] K_NONE = 4'd15;

  localparam logic [DEPTH*8-1:0] ALL_SPACE = {DEPTH{8'h20}};

  if (DEPTH < 2 || DEPTH > 64 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16777216) begin : g_param_check
    $error("multitap_text_buffer: parameter out of range");
  end

  function automatic logic [3:0] decode(input logic [7:0] code);
    case (code)
      8'h82:   return 4'd0;
      8'h11:   return 4'd1;
      8'h12:   return 4'd2;
      8'h14:   return 4'd3;
      8'h21:   return 4'd4;
      8'h22:   return 4'd5;
      8'h24:   return 4'd6;
      8'h41:   return 4'd7;
      8'h42:   return 4'd8;
      8'h44:   return 4'd9;
      8'h81:   return K_STAR;
      8'h84:   return K_HASH;
      8'h18:   return K_A;
      8'h48:   return K_C;
      8'h88:   return K_D;
      default: return K_NONE;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [3:0] k);
    return (k == 4'd0 || k == 4'd1 || k == 4'd7 || k == 4'd9 || k == K_STAR) ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [7:0] tap_char(input logic [3:0] k, input logic [1:0] i, input logic up);
    logic [7:0] base;
    logic [7:0] c;
    base = 8'h61;
    c    = 8'h20;
    case (k)
      4'd0: case (i)
              2'd0: c = 8'h2C;
              2'd1: c = 8'h2E;
              2'd2: c = 8'h3F;
              default: c = 8'h21;
            endcase
      4'd1: case (i)
              2'd0: c = 8'h40;
              2'd1: c = 8'h5F;
              2'd2: c = 8'h26;
              default: c = 8'h3A;
            endcase
      K_STAR: case (i)
              2'd0: c = 8'h2B;
              2'd1: c = 8'h2D;
              2'd2: c = 8'h2F;
              default: c = 8'h3D;
            endcase
      default: begin
        case (k)
          4'd3:    base = 8'h64;
          4'd4:    base = 8'h67;
          4'd5:    base = 8'h6A;
          4'd6:    base = 8'h6D;
          4'd7:    base = 8'h70;
          4'd8:    base = 8'h74;
          4'd9:    base = 8'h77;
          default: base = 8'h61;
        endcase
        c = base + {6'd0, i};
        if (up) c = c - 8'h20;
      end
    endcase
    return c;
  endfunction

  logic [1:0]         state, state_nx;
  logic [DEPTH*8-1:0] text, text_nx;
  logic [CW-1:0]      count, count_nx;
  logic [7:0]         pend, pend_nx;
  logic [3:0]         tap_key, tap_key_nx;
  logic [1:0]         tap_idx, tap_idx_nx;
  logic               c1_en, c2_en, go_send;
  logic [7:0]         c2_ch;
  logic [3:0]         key;
  logic               is_tap, accept, composing, expire;

  assign key       = decode(bus.key_code);
  assign is_tap    = (key <= K_STAR);
  assign composing = (state == S_COMPOSE);
  assign accept    = bus.key_valid && (state != S_SEND);

`ifdef MULTITAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer;

  assign expire = composing && !bus.key_valid && (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_nx != S_COMPOSE || bus.key_valid) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text    <= ALL_SPACE;
      count   <= '0;
      pend    <= 8'h20;
      tap_key <= '0;
      tap_idx <= '0;
    end else begin
      text    <= text_nx;
      count   <= count_nx;
      pend    <= pend_nx;
      tap_key <= tap_key_nx;
      tap_idx <= tap_idx_nx;
    end
  end

  // Up to two commits per update: c1 is always the pending letter, c2 a second character.
  always_comb begin
    state_nx   = state;
    text_nx    = text;
    count_nx   = count;
    pend_nx    = pend;
    tap_key_nx = tap_key;
    tap_idx_nx = tap_idx;
    c1_en      = 1'b0;
    c2_en      = 1'b0;
    c2_ch      = 8'h20;
    go_send    = 1'b0;

    case (state)
      S_SEND: begin
        if (bus.tx_ready) begin
          count_nx = count - CW'(1);
          if (count == CW'(1)) begin
            text_nx  = ALL_SPACE;
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        if (accept) begin
          if (is_tap && !bus.mode) begin
            c1_en    = composing;
            c2_en    = 1'b1;
            c2_ch    = (key == K_STAR) ? 8'h2A : (8'h30 + {4'd0, key});
            state_nx = S_IDLE;
            pend_nx  = 8'h20;
          end else if (is_tap) begin
            if (composing && key == tap_key) begin
              tap_idx_nx = (tap_idx == last_idx(key)) ? 2'd0 : tap_idx + 2'd1;
            end else begin
              c1_en      = composing;
              tap_key_nx = key;
              tap_idx_nx = 2'd0;
            end
            state_nx = S_COMPOSE;
            pend_nx  = tap_char(key, tap_idx_nx, bus.upper);
          end else begin
            case (key)
              K_HASH: begin
                c1_en    = composing;
                state_nx = S_IDLE;
                pend_nx  = 8'h20;
              end
              K_A: begin
                if (composing) begin
                  state_nx = S_IDLE;
                  pend_nx  = 8'h20;
                end else if (count != '0) begin
                  text_nx  = {8'h20, text[DEPTH*8-1:8]};
                  count_nx = count - CW'(1);
                end
              end
              K_C: begin
                c1_en    = composing;
                c2_en    = 1'b1;
                state_nx = S_IDLE;
                pend_nx  = 8'h20;
              end
              K_D: begin
                c1_en    = composing;
                go_send  = 1'b1;
                state_nx = S_IDLE;
                pend_nx  = 8'h20;
              end
              default: ;
            endcase
          end
        end else if (expire) begin
          c1_en    = 1'b1;
          state_nx = S_IDLE;
          pend_nx  = 8'h20;
        end
      end
    endcase

    if (c1_en && count_nx != CW'(DEPTH)) begin
      text_nx  = {text_nx[DEPTH*8-9:0], pend};
      count_nx = count_nx + CW'(1);
    end
    if (c2_en && count_nx != CW'(DEPTH)) begin
      text_nx  = {text_nx[DEPTH*8-9:0], c2_ch};
      count_nx = count_nx + CW'(1);
    end
    if (go_send && count_nx != '0) state_nx = S_SEND;
  end

  // Oldest committed character sits at slot count-1.
  always_comb begin
    bus.tx_valid = (state == S_SEND);
    bus.tx_data  = 8'h00;
    if (state == S_SEND) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count == CW'(i + 1)) bus.tx_data = text[i*8 +: 8];
      end
    end
  end

  assign bus.buf_out    = text;
  assign bus.pend_char  = pend;
  assign bus.char_count = count;
  assign bus.full       = (count == CW'(DEPTH));
  assign bus.busy       = (state == S_SEND);

endmodule
`default_nettype wire

// File: tb/tb_multitap_text_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multitap_text_buffer : directed bench with a queue-based model   |
// | checked every cycle. Revision: 1.0                                  |
// +--------------------------------------------------------------------+
module tb_multitap_text_buffer;
  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multitap_text_buffer_if #(.DEPTH(DEPTH)) bus ();

  multitap_text_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: committed text as a queue, oldest first.
  byte unsigned q[$];
  bit           m_send = 1'b0;
  bit           m_comp = 1'b0;
  byte unsigned m_pend = 8'h20;
  int           m_key  = 0;
  int           m_idx  = 0;
  int           m_idle = 0;
  string        groups[11] = '{",.?!", "@_&:", "abc", "def", "ghi", "jkl",
                                "mno", "pqrs", "tuv", "wxyz", "+-/="};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [7:0] c);
    case (c)
      8'h82: return 0;  8'h11: return 1;  8'h12: return 2;  8'h14: return 3;
      8'h21: return 4;  8'h22: return 5;  8'h24: return 6;  8'h41: return 7;
      8'h42: return 8;  8'h44: return 9;  8'h81: return 10; 8'h84: return 11;
      8'h18: return 12; 8'h48: return 13; 8'h88: return 14;
      default: return -1;
    endcase
  endfunction

  function automatic byte unsigned tap(input int k, input int i, input bit up);
    byte unsigned ch;
    ch = groups[k][i];
    if (up && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
    return ch;
  endfunction

  task automatic model_commit(input byte unsigned ch);
    if (q.size() < DEPTH) q.push_back(ch);
  endtask

  task automatic model_reset();
    q.delete();
    m_send = 1'b0;
    m_comp = 1'b0;
    m_pend = 8'h20;
    m_idle = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] kc, input bit rdy);
    int k;
    if (m_send) begin
      if (rdy) begin
        q.delete(0);
        if (q.size() == 0) m_send = 1'b0;
      end
      return;
    end
    k = kv ? key_of(kc) : -1;
    if (kv) m_idle = 0;
`ifdef MULTITAP_TIMEOUT_EN
    if (m_comp && !kv) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYC) begin
        model_commit(m_pend);
        m_comp = 1'b0;
      end
    end
`endif
    if (k >= 0 && k <= 10) begin
      if (!bus.mode) begin
        if (m_comp) model_commit(m_pend);
        m_comp = 1'b0;
        model_commit(k == 10 ? 8'h2A : byte'(8'h30 + k));
      end else if (m_comp && k == m_key) begin
        m_idx  = (m_idx + 1) % groups[k].len();
        m_pend = tap(k, m_idx, bus.upper);
      end else begin
        if (m_comp) model_commit(m_pend);
        m_comp = 1'b1;
        m_key  = k;
        m_idx  = 0;
        m_pend = tap(k, 0, bus.upper);
      end
    end else begin
      case (k)
        11: begin
          if (m_comp) model_commit(m_pend);
          m_comp = 1'b0;
        end
        12: begin
          if (m_comp) m_comp = 1'b0;
          else if (q.size() > 0) q.delete(q.size() - 1);
        end
        13: begin
          if (m_comp) model_commit(m_pend);
          m_comp = 1'b0;
          model_commit(8'h20);
        end
        14: begin
          if (m_comp) model_commit(m_pend);
          m_comp = 1'b0;
          if (q.size() > 0) m_send = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [DEPTH*8-1:0] exp_buf();
    logic [DEPTH*8-1:0] b;
    for (int i = 0; i < DEPTH; i++)
      b[i*8 +: 8] = (i < q.size()) ? q[q.size() - 1 - i] : 8'h20;
    return b;
  endfunction

  initial forever begin
    @(negedge clk);
    check("char_count", bus.char_count, q.size());
    check("full", bus.full, q.size() == DEPTH);
    check("busy", bus.busy, m_send);
    check("tx_valid", bus.tx_valid, m_send);
    check("pend_char", bus.pend_char, m_comp ? m_pend : 8'h20);
    if (m_send) check("tx_data", bus.tx_data, q[0]);
    else begin
      check("tx_data_idle", bus.tx_data, 8'h00);
      check("buf_out", bus.buf_out, exp_buf());
    end
  end

  task automatic step(input bit kv, input logic [7:0] kc, input bit rdy);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.tx_ready  = rdy;
    @(posedge clk);
    model_step(kv, kc, rdy);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] kc);
    step(1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  byte unsigned pq[5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.mode      = 1'b0;
    bus.upper     = 1'b0;
    bus.tx_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_buf", bus.buf_out, 32'h20202020);
    check("rst_pend", bus.pend_char, 8'h20);
    check("rst_count", bus.char_count, 0);
    check("rst_txv", bus.tx_valid, 1'b0);
    check("rst_txd", bus.tx_data, 8'h00);

    // Lowercase taps on 2 then 3
    bus.mode = 1'b1; bus.upper = 1'b0;
    press(8'h12); check("tap_a", bus.pend_char, 8'h61);
    press(8'h12); press(8'h12); check("tap_c", bus.pend_char, 8'h63);
    press(8'h14);
    check("tap_d", bus.pend_char, 8'h64);
    check("commit_c", bus.buf_out[7:0], 8'h63);
    check("count_1", bus.char_count, 1);
    press(8'h84); check("hash_cd", bus.buf_out[15:0], 16'h6364);
    press(8'h18); press(8'h18); check("bs_empty", bus.char_count, 0);

    // Uppercase wrap on the 4-letter group
    bus.upper = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press(8'h41);
      check("tap_pqrs", bus.pend_char, pq[i]);
    end
    press(8'h84); check("commit_P", bus.buf_out[7:0], 8'h50);
    press(8'h18);

    // Number entry up to full, drop, backspace
    bus.mode = 1'b0;
    press(8'h11); press(8'h12); press(8'h14); press(8'h21); press(8'h22);
    check("num_buf", bus.buf_out, 32'h31323334);
    check("num_full", bus.full, 1'b1);
    press(8'h18);
    check("bs_count", bus.char_count, 3);
    check("bs_low", bus.buf_out[7:0], 8'h33);
    press(8'h18); press(8'h18); press(8'h18); press(8'h18);
    check("bs_noop", bus.char_count, 0);

    // B ignored, digit commits pending, A discards, C adds space
    bus.mode = 1'b1; bus.upper = 1'b0;
    press(8'h22); press(8'h28); check("b_ignored", bus.pend_char, 8'h6A);
    bus.mode = 1'b0; press(8'h12);
    check("digit_after_pend", bus.buf_out[15:0], 16'h6A32);
    bus.mode = 1'b1;
    press(8'h24); press(8'h18);
    check("a_discard", bus.pend_char, 8'h20);
    check("a_keep", bus.char_count, 2);
    press(8'h24); press(8'h48);
    check("c_space", bus.buf_out, 32'h6A326D20);
    press(8'h48); check("c_full_drop", bus.char_count, 4);
    press(8'h18); press(8'h18); press(8'h18); press(8'h18);
    press(8'h88); check("d_empty", bus.busy, 1'b0);

    // Send "HI" with a stall, keys ignored while busy
    bus.upper = 1'b1;
    press(8'h21); press(8'h21); press(8'h84);
    press(8'h21); press(8'h21); press(8'h21); press(8'h88);
    check("send_busy", bus.busy, 1'b1);
    check("send_H", bus.tx_data, 8'h48);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h11, 1'b0);
      check("stall_H", bus.tx_data, 8'h48);
      check("stall_count", bus.char_count, 2);
    end
    step(1'b0, 8'h00, 1'b1);
    check("send_I", bus.tx_data, 8'h49);
    step(1'b0, 8'h00, 1'b1);
    check("send_done", bus.busy, 1'b0);
    check("send_txv", bus.tx_valid, 1'b0);
    check("send_buf", bus.buf_out, 32'h20202020);

    // Reset in the middle of a send
    bus.mode = 1'b0;
    press(8'h11); press(8'h12); press(8'h14); press(8'h88);
    step(1'b0, 8'h00, 1'b1);
    check("mid_count", bus.char_count, 2);
    rst = 1'b1;
    #1;
    check("arst_txv", bus.tx_valid, 1'b0);
    check("arst_count", bus.char_count, 0);
    check("arst_buf", bus.buf_out, 32'h20202020);
    model_reset();
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    bus.mode = 1'b1; bus.upper = 1'b0;
`ifdef MULTITAP_TIMEOUT_EN
    press(8'h22); idle(7);
    check("to_pending", bus.pend_char, 8'h6A);
    idle(1);
    check("to_commit", bus.buf_out[7:0], 8'h6A);
    check("to_idle", bus.pend_char, 8'h20);
    press(8'h18);
    press(8'h22); idle(7); press(8'h22);
    check("to_key_wins", bus.pend_char, 8'h6B);
    check("to_no_commit", bus.char_count, 0);
`else
    press(8'h22); idle(20);
    check("no_timeout", bus.pend_char, 8'h6A);
    check("no_timeout_cnt", bus.char_count, 0);
`endif
    press(8'h84);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
